// File: rtl/calc_disp_ctrl.sv
// calc_disp_ctrl: display controller that sits directly in front of the
// seven-segment decoder.
//
// It accepts signed calculator results over a valid/ready handshake and turns
// each one into a sign and an 8-bit magnitude. Results that are out of range
// or flagged as errors switch the display to a sticky "ERR" message. Timed
// "OP" and "VAL" prompts fall back to the last number on their own.
//
// Optional feature (compile-time macro DISP_CTRL_SAT_EN):
//   - Defined: a magnitude above 255 is saturated to 255 and written as a
//     normal number. Only res_err leads to ERR.
//   - Undefined: a magnitude above 255 is a range error and leads to ERR.
module calc_disp_ctrl #(
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [1:0]        res_dot,
  input  logic              res_err,
  input  logic              prompt_op,
  input  logic              prompt_val,
  input  logic              clr_err,
  output logic [1:0]        msg,
  output logic              display_sel,
  output logic              wr_enable,
  output logic [7:0]        bin,
  output logic              sgn,
  output logic [1:0]        dot,
  output logic              busy
);

  // Message codes understood by the decoder.
  localparam logic [1:0] MSG_NUM = 2'b00;
  localparam logic [1:0] MSG_OP  = 2'b01;
  localparam logic [1:0] MSG_VAL = 2'b10;
  localparam logic [1:0] MSG_ERR = 2'b11;

  // Counter reload value: the prompt is shown for HOLD_CYCLES cycles,
  // counting the loading cycle down to zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // Largest magnitude that fits the 8-bit decoder input.
  localparam logic [DATA_W:0] MAG_MAX = (DATA_W+1)'(255);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_HOLD,
    S_ERR
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       msg_q;
  logic             sel_q;
  logic             wr_q;
  logic [7:0]       bin_q;
  logic             sgn_q;
  logic             neg_q;
  logic [1:0]       dot_q;
  logic             busy_q;
  logic             ready_q;

  // Absolute value, computed one bit wider than the input so that the most
  // negative value (-2^(DATA_W-1)) becomes a large positive magnitude instead
  // of wrapping back to itself.
  function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] e;
    e = {v[DATA_W-1], v};
    abs_ext = v[DATA_W-1] ? -e : e;
  endfunction

  // Magnitude presented to the decoder. Out-of-range values are clamped to
  // 255. In the non-saturating build they never reach the decoder, because
  // they are routed to ERR instead.
  function automatic logic [7:0] sat8(input logic [DATA_W:0] m);
    sat8 = (m > MAG_MAX) ? 8'hFF : m[7:0];
  endfunction

  logic signed [DATA_W-1:0] data_s;
  logic [DATA_W:0]          mag_d;
  logic                     neg_d;
  logic [7:0]               bin_d;
  logic                     range_err_d;
  logic                     xfer;

  assign data_s = res_data;
  assign mag_d  = abs_ext(data_s);
  assign neg_d  = res_data[DATA_W-1];
  assign bin_d  = sat8(mag_d);
  assign xfer   = res_valid & ready_q;

`ifdef DISP_CTRL_SAT_EN
  assign range_err_d = res_err;
`else
  assign range_err_d = res_err | (mag_d > MAG_MAX);
`endif

  // Control FSM with registered display outputs.
  // Priority of simultaneous events: transfer, clr_err, prompt_op, prompt_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      msg_q   <= MSG_NUM;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      bin_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      dot_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_WRITE: begin
          // The one-cycle strobe has been seen by the decoder; drop it and
          // accept the next result.
          wr_q    <= 1'b0;
          sel_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          if (xfer) begin
            // A new result always wins and aborts any running prompt.
            busy_q <= 1'b0;
            cnt_q  <= '0;
            if (range_err_d) begin
              // bin and dot keep the last number so clr_err can restore it.
              // Only the displayed sign is blanked.
              state_q <= S_ERR;
              msg_q   <= MSG_ERR;
              sgn_q   <= 1'b0;
            end else begin
              state_q <= S_WRITE;
              msg_q   <= MSG_NUM;
              bin_q   <= bin_d;
              neg_q   <= neg_d;
              sgn_q   <= neg_d;
              dot_q   <= res_dot;
              wr_q    <= 1'b1;
              sel_q   <= 1'b1;
              ready_q <= 1'b0;
            end
          end else if (state_q == S_ERR) begin
            // Prompts are ignored while an error is shown.
            if (clr_err) begin
              // The decoder still holds bin, so the previous number shows
              // again without a rewrite. Its sign is restored here.
              state_q <= S_IDLE;
              msg_q   <= MSG_NUM;
              sgn_q   <= neg_q;
            end
          end else if (prompt_op || prompt_val) begin
            // A prompt starts or restarts the hold window.
            state_q <= S_HOLD;
            msg_q   <= prompt_op ? MSG_OP : MSG_VAL;
            cnt_q   <= HOLD_LOAD;
            busy_q  <= 1'b1;
          end else if (state_q == S_HOLD) begin
            if (cnt_q == '0) begin
              // The decoder still holds bin, so no rewrite is issued.
              state_q <= S_IDLE;
              msg_q   <= MSG_NUM;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign res_ready   = ready_q;
  assign msg         = msg_q;
  assign display_sel = sel_q;
  assign wr_enable   = wr_q;
  assign bin         = bin_q;
  assign sgn         = sgn_q;
  assign dot         = dot_q;
  assign busy        = busy_q;

endmodule
